// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter.
// Optional feature: ARB_ROUND_ROBIN_EN (see arb_pick2).
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int unsigned DEF_DATA_LENGTH = 32;
  localparam int unsigned DEF_ADDR_LENGTH = 10;
  localparam int unsigned DEF_MEM_LATENCY = 1;

  // Width of a down-counter that must hold the value lat.
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle of the I/D memory arbiter.
// slave = arbiter view, master = requesters plus memory macro view.
interface mem_arbiter_if #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned ADDR_LENGTH = 10
);
  logic                   i_valid;
  logic [ADDR_LENGTH-1:0] i_addr;
  logic                   i_ready;
  logic                   i_resp_valid;
  logic [DATA_LENGTH-1:0] i_rdata;

  logic                   d_valid;
  logic                   d_we;
  logic [ADDR_LENGTH-1:0] d_addr;
  logic [DATA_LENGTH-1:0] d_wdata;
  logic                   d_ready;
  logic                   d_resp_valid;
  logic [DATA_LENGTH-1:0] d_rdata;

  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_LENGTH-1:0] mem_addr;
  logic [DATA_LENGTH-1:0] mem_wdata;
  logic [DATA_LENGTH-1:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, i_resp_valid, i_rdata, d_ready, d_resp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_resp_valid, i_rdata, d_ready, d_resp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_arb_pick2.sv
// Combinational 2-way picker for the I/D arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise D has fixed priority.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  arb_owner_t last_grant,
  output arb_owner_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = OWN_I;
    if (i_valid && d_valid)
      grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
    else if (d_valid)
      grant = OWN_D;
  end
`else
  // Result is only consumed when some valid is set, so i_valid is implied.
  logic [1:0] unused_in;
  assign unused_in = {i_valid, last_grant == OWN_D};

  always_comb begin
    grant = OWN_I;
    if (d_valid)
      grant = OWN_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and data (D).
// One outstanding transaction; ARB_ROUND_ROBIN_EN enables round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned ADDR_LENGTH = DEF_ADDR_LENGTH,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = lat_cnt_w(MEM_LATENCY);

  arb_state_t       state;
  arb_owner_t       owner;
  arb_owner_t       last_grant;
  arb_owner_t       winner;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             resp;

  arb_pick2 u_pick (
    .i_valid    (bus.i_valid),
    .d_valid    (bus.d_valid),
    .last_grant (last_grant),
    .grant      (winner)
  );

  // Gating with reset keeps every output at 0 while reset is held.
  assign accept = !reset && (state == ARB_IDLE) && (bus.i_valid || bus.d_valid);
  assign resp   = !reset && (state == ARB_BUSY) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= OWN_I;
      cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            state <= ARB_BUSY;
            owner <= winner;
            cnt   <= CNT_W'(MEM_LATENCY);
          end
        end
        ARB_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= OWN_I;
    else if (accept)
      last_grant <= winner;
  end
`else
  assign last_grant = OWN_I;
`endif

  always_comb begin
    bus.i_ready      = 1'b0;
    bus.d_ready      = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (accept) begin
      bus.mem_en = 1'b1;
      if (winner == OWN_D) begin
        bus.d_ready   = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
      end else begin
        bus.i_ready  = 1'b1;
        bus.mem_addr = bus.i_addr;
      end
    end
  end

  // Read data is a passthrough of the macro output, qualified by the pulse.
  always_comb begin
    bus.i_resp_valid = 1'b0;
    bus.d_resp_valid = 1'b0;
    bus.i_rdata      = '0;
    bus.d_rdata      = '0;
    if (resp) begin
      if (owner == OWN_D) begin
        bus.d_resp_valid = 1'b1;
        bus.d_rdata      = bus.mem_rdata;
      end else begin
        bus.i_resp_valid = 1'b1;
        bus.i_rdata      = bus.mem_rdata;
      end
    end
  end

endmodule
